// File: rtl/grammer_out_collector_if.sv
// Bundle between the sample producer, the grammer_out_collector and its result consumer.
// Both channels are valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1;
// the input channel has no ready wire, and its "ready" is !fifo_full.
interface grammer_out_collector_if #(
    parameter int DW    = 32,
    parameter int BLOCK = 4
);
    localparam int SW = DW + $clog2(BLOCK);

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          out_valid;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_max;
    logic [7:0]    out_block;
    logic          fifo_full;
    logic [7:0]    drop_cnt;
    logic [1:0]    dbg_state;

    modport master (
        input  in_valid, in_data, out_ready,
        output out_valid, out_sum, out_max, out_block, fifo_full, drop_cnt, dbg_state
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  out_valid, out_sum, out_max, out_block, fifo_full, drop_cnt, dbg_state
    );
endinterface

// File: rtl/grammer_out_collector.sv
// Buffers 'out' samples in a small FIFO and reduces every BLOCK samples to sum, max and index.
// The FSM state is exported as dbg_state (0 IDLE, 1 ACCUM, 2 EMIT).
module grammer_out_collector #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int BLOCK = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    grammer_out_collector_if.master   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BLOCK);
    localparam int SW = DW + CW;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [7:0]    drop_cnt_q;

    logic [1:0]    state;
    logic [SW-1:0] sum, sum_n, out_sum_q;
    logic [DW-1:0] max, max_n, out_max_q, sample;
    logic [CW-1:0] scnt;
    logic          out_valid_q;
    logic [7:0]    out_block_q;

    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty  = (wr_ptr == rd_ptr);
    // No bypass: a full FIFO rejects the push even when a pop frees a slot this cycle.
    assign push   = bus.in_valid && !full;
    assign pop    = (state == ACCUM) && !empty;
    assign sample = mem[rd_ptr[AW-1:0]];

    assign sum_n  = sum + SW'(sample);
    assign max_n  = (sample > max) ? sample : max;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt_q <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (bus.in_valid && full && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    // The last pop of a block publishes sum_n/max_n directly so the result appears without an extra cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sum         <= '0;
            max         <= '0;
            scnt        <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_block_q <= 8'd0;
        end else begin
            case (state)
                IDLE: if (en) state <= ACCUM;
                ACCUM: begin
                    if (pop) begin
                        if (scnt == CW'(BLOCK - 1)) begin
                            out_sum_q   <= sum_n;
                            out_max_q   <= max_n;
                            out_valid_q <= 1'b1;
                            state       <= EMIT;
                        end else begin
                            sum  <= sum_n;
                            max  <= max_n;
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        sum         <= '0;
                        max         <= '0;
                        scnt        <= '0;
                        out_block_q <= out_block_q + 8'd1;
                        state       <= en ? ACCUM : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_block = out_block_q;
    assign bus.fifo_full = full;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_grammer_out_collector.sv
// Directed bench for grammer_out_collector: expected results queue up as samples are issued,
// and a monitor compares them against every accepted output.
module tb_grammer_out_collector;
  localparam int RW = 34 + 32 + 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  grammer_out_collector_if #(.DW(32), .BLOCK(4)) bus ();

  grammer_out_collector #(.DW(32), .DEPTH(4), .BLOCK(4)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // driver tasks: all inputs change 1 ns after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic push_sample(input logic [31:0] v);
    bus.in_valid = 1'b1;
    bus.in_data = v;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_when_space(input logic [31:0] v);
    for (int i = 0; i < 50 && bus.fifo_full; i++) tick();
    push_sample(v);
  endtask

  task automatic expect_result(input logic [33:0] s, input logic [31:0] m, input logic [7:0] b);
    exp_q.push_back({s, m, b});
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) tick();
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // scoreboard monitor: a result is consumed at the next edge when valid && ready
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      logic [RW-1:0] e;
      logic [RW-1:0] a;
      a = {bus.out_sum, bus.out_max, bus.out_block};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result actual=%0h expected=none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL result actual sum=%0h max=%0h blk=%0d expected sum=%0h max=%0h blk=%0d",
                   a[73:40], a[39:8], a[7:0], e[73:40], e[39:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    tick();
    // reset state
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.out_sum), 64'd0);
    check("rst_max", 64'(bus.out_max), 64'd0);
    check("rst_block", 64'(bus.out_block), 64'd0);
    check("rst_full", 64'(bus.fifo_full), 64'd0);
    check("rst_drop", 64'(bus.drop_cnt), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'd0);

    // T1 basic, including BLOCK-cycle latency
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    expect_result(34'd100, 32'd40, 8'd0);
    push_sample(32'd10);
    push_sample(32'd20);
    push_sample(32'd30);
    push_sample(32'd40);
    check("t1_lat_early", 64'(bus.out_valid), 64'd0);
    tick();
    check("t1_lat_valid", 64'(bus.out_valid), 64'd1);
    wait_drain(20);
    tick();
    check("t1_single_pulse", 64'(bus.out_valid), 64'd0);

    // T2 backpressure and drops
    do_reset();
    en = 1'b1;
    tick();
    tick();
    expect_result(34'd10, 32'd4, 8'd0);
    expect_result(34'd26, 32'd8, 8'd1);
    for (int i = 1; i <= 12; i++) push_sample(32'(i));
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    check("t2_sum", 64'(bus.out_sum), 64'd10);
    check("t2_max", 64'(bus.out_max), 64'd4);
    check("t2_full", 64'(bus.fifo_full), 64'd1);
    check("t2_drop", 64'(bus.drop_cnt), 64'd4);
    check("t2_state", 64'(bus.dbg_state), 64'd2);
    tick();
    tick();
    tick();
    check("t2_hold_sum", 64'(bus.out_sum), 64'd10);
    check("t2_hold_block", 64'(bus.out_block), 64'd0);
    bus.out_ready = 1'b1;
    wait_drain(40);
    expect_result(34'd42, 32'd12, 8'd2);
    for (int i = 9; i <= 12; i++) push_when_space(32'(i));
    wait_drain(40);

    // T3 extremes
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    expect_result(34'h3_FFFF_FFFC, 32'hFFFF_FFFF, 8'd0);
    expect_result(34'd1, 32'd1, 8'd1);
    for (int i = 0; i < 4; i++) push_when_space(32'hFFFF_FFFF);
    push_when_space(32'd0);
    push_when_space(32'd0);
    push_when_space(32'd0);
    push_when_space(32'd1);
    wait_drain(40);

    // T4 reset mid-block
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    push_sample(32'd7);
    push_sample(32'd8);
    reset = 1'b0;
    #1;
    check("t4_valid", 64'(bus.out_valid), 64'd0);
    check("t4_sum", 64'(bus.out_sum), 64'd0);
    check("t4_max", 64'(bus.out_max), 64'd0);
    check("t4_full", 64'(bus.fifo_full), 64'd0);
    check("t4_state", 64'(bus.dbg_state), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    expect_result(34'd10, 32'd4, 8'd0);
    for (int i = 1; i <= 4; i++) push_when_space(32'(i));
    wait_drain(40);

    // T5 block index wrap
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    for (int b = 0; b < 257; b++) begin
      expect_result(34'(16 * b + 10), 32'(4 * b + 4), 8'(b));
      for (int j = 0; j < 4; j++) push_when_space(32'(4 * b + j + 1));
    end
    wait_drain(100);
    tick();
    check("t5_block_wrap", 64'(bus.out_block), 64'd1);

    // T5 drop counter saturation
    do_reset();
    en = 1'b1;
    tick();
    tick();
    for (int i = 1; i <= 320; i++) push_sample(32'(i));
    check("t5_drop_sat", 64'(bus.drop_cnt), 64'd255);
    check("t5_full", 64'(bus.fifo_full), 64'd1);
    check("t5_held_sum", 64'(bus.out_sum), 64'd10);

    // T6 en low mid-block
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    tick();
    expect_result(34'd26, 32'd8, 8'd0);
    push_sample(32'd5);
    push_sample(32'd6);
    en = 1'b0;
    push_sample(32'd7);
    push_sample(32'd8);
    wait_drain(20);
    tick();
    tick();
    check("t6_idle", 64'(bus.dbg_state), 64'd0);
    for (int i = 1; i <= 5; i++) push_sample(32'(i));
    check("t6_full", 64'(bus.fifo_full), 64'd1);
    check("t6_no_valid", 64'(bus.out_valid), 64'd0);
    check("t6_drop", 64'(bus.drop_cnt), 64'd1);
    expect_result(34'd10, 32'd4, 8'd1);
    en = 1'b1;
    wait_drain(40);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
